// File: rtl/clock_time_ctrl_if.sv
// Signal bundle between the clock divider/buttons and the timekeeping controller.
// The master side drives the 1 Hz wave and buttons; the slave side returns time and mode.
interface clock_time_ctrl_if;
  logic       sec_clk;
  logic       mode_btn;
  logic       inc_btn;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic       blink;
  logic       day_tick;

  modport master (
    output sec_clk, mode_btn, inc_btn,
    input  hours, minutes, seconds, mode, blink, day_tick
  );

  modport slave (
    input  sec_clk, mode_btn, inc_btn,
    output hours, minutes, seconds, mode, blink, day_tick
  );
endinterface

// File: rtl/clock_time_ctrl.sv
// HH:MM:SS timekeeper with RUN / SET_HR / SET_MIN set-mode FSM and idle timeout.
// Latency: outputs update on the clk edge where a rising input is first sampled; no backpressure.
module clock_time_ctrl #(
  parameter int TIMEOUT_S = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  clock_time_ctrl_if.slave   tc
);

  localparam int TW = (TIMEOUT_S < 1) ? 1 : $clog2(TIMEOUT_S + 1);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_S > 0) ? TIMEOUT_S - 1 : 0);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          sec_prev_q, mode_prev_q, inc_prev_q;
  logic [4:0]    hours_q, hours_d;
  logic [5:0]    minutes_q, minutes_d;
  logic [5:0]    seconds_q, seconds_d;
  logic          blink_q, blink_d;
  logic          day_tick_q, day_tick_d;
  logic [TW-1:0] to_q, to_d;

  logic tick, mode_ev, inc_ev, expire;

  assign tick    = tc.sec_clk  & ~sec_prev_q;
  assign mode_ev = tc.mode_btn & ~mode_prev_q;
  assign inc_ev  = tc.inc_btn  & ~inc_prev_q;
  // Any button edge restarts the idle window, so only a quiet tick can expire it.
  assign expire  = (TIMEOUT_S != 0) && tick && !mode_ev && !inc_ev && (to_q == TO_LAST);

  always_comb begin
    state_d    = state_q;
    hours_d    = hours_q;
    minutes_d  = minutes_q;
    seconds_d  = seconds_q;
    blink_d    = blink_q;
    day_tick_d = 1'b0;
    to_d       = to_q;

    case (state_q)
      RUN: begin
        if (tick) begin
          if (seconds_q == 6'd59) begin
            seconds_d = 6'd0;
            if (minutes_q == 6'd59) begin
              minutes_d = 6'd0;
              if (hours_q == 5'd23) begin
                hours_d    = 5'd0;
                day_tick_d = 1'b1;
              end else begin
                hours_d = hours_q + 5'd1;
              end
            end else begin
              minutes_d = minutes_q + 6'd1;
            end
          end else begin
            seconds_d = seconds_q + 6'd1;
          end
        end
        if (mode_ev) begin
          state_d = SET_HR;
          blink_d = 1'b0;
          to_d    = '0;
        end
      end

      SET_HR, SET_MIN: begin
        if (mode_ev) begin
          state_d = (state_q == SET_HR) ? SET_MIN : RUN;
          blink_d = 1'b0;
          to_d    = '0;
          if (state_q == SET_MIN) seconds_d = 6'd0;
        end else if (inc_ev) begin
          if (state_q == SET_HR)
            hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
          else
            minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
          blink_d = 1'b0;
          to_d    = '0;
        end else if (expire) begin
          state_d = RUN;
          blink_d = 1'b0;
          to_d    = '0;
          if (state_q == SET_MIN) seconds_d = 6'd0;
        end else if (tick) begin
          blink_d = ~blink_q;
          to_d    = to_q + TW'(1);
        end
      end

      default: begin
        state_d = RUN;
        blink_d = 1'b0;
        to_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      sec_prev_q  <= 1'b0;
      mode_prev_q <= 1'b1;
      inc_prev_q  <= 1'b1;
      hours_q     <= 5'd0;
      minutes_q   <= 6'd0;
      seconds_q   <= 6'd0;
      blink_q     <= 1'b0;
      day_tick_q  <= 1'b0;
      to_q        <= '0;
    end else begin
      state_q     <= state_d;
      sec_prev_q  <= tc.sec_clk;
      mode_prev_q <= tc.mode_btn;
      inc_prev_q  <= tc.inc_btn;
      hours_q     <= hours_d;
      minutes_q   <= minutes_d;
      seconds_q   <= seconds_d;
      blink_q     <= blink_d;
      day_tick_q  <= day_tick_d;
      to_q        <= to_d;
    end
  end

  assign tc.hours    = hours_q;
  assign tc.minutes  = minutes_q;
  assign tc.seconds  = seconds_q;
  assign tc.mode     = state_q;
  assign tc.blink    = blink_q;
  assign tc.day_tick = day_tick_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed-vector bench for clock_time_ctrl with hand-computed expected values.
// Inputs change on the falling clock edge; outputs are checked away from the rising edge.
module tb_clock_time_ctrl;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  clock_time_ctrl_if tc ();

  clock_time_ctrl #(.TIMEOUT_S(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tc    (tc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Raise the selected inputs for one cycle, then drop them for one cycle; repeat n times.
  task automatic ev(input logic s, input logic m, input logic i, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      tc.sec_clk  = s;
      tc.mode_btn = m;
      tc.inc_btn  = i;
      @(negedge clk);
      tc.sec_clk  = 1'b0;
      tc.mode_btn = 1'b0;
      tc.inc_btn  = 1'b0;
    end
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, ".hours"},   int'(tc.hours),   h);
    chk({tag, ".minutes"}, int'(tc.minutes), m);
    chk({tag, ".seconds"}, int'(tc.seconds), s);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    tc.sec_clk  = 1'b0;
    tc.mode_btn = 1'b0;
    tc.inc_btn  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_time("reset", 0, 0, 0);
    chk("reset.mode", int'(tc.mode), 0);
    chk("reset.blink", int'(tc.blink), 0);
    chk("reset.day_tick", int'(tc.day_tick), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Mode cycle with field increments and wrap
    ev(0, 1, 0, 1);
    chk("set_hr.mode", int'(tc.mode), 1);
    ev(0, 0, 1, 25);
    chk("inc25.hours", int'(tc.hours), 1);
    chk("inc25.blink", int'(tc.blink), 0);
    ev(0, 1, 0, 1);
    chk("set_min.mode", int'(tc.mode), 2);
    ev(0, 0, 1, 61);
    chk_time("inc61", 1, 1, 0);
    ev(0, 1, 0, 1);
    chk("run.mode", int'(tc.mode), 0);

    // RUN counts seconds and ignores inc_btn
    ev(1, 0, 0, 3);
    chk_time("run3", 1, 1, 3);
    ev(0, 0, 1, 1);
    chk_time("run_inc_ignored", 1, 1, 3);

    // Preload 23:59, leaving SET_MIN clears seconds
    ev(0, 1, 0, 1);
    ev(0, 0, 1, 22);
    ev(0, 1, 0, 1);
    ev(0, 0, 1, 58);
    chk_time("preload", 23, 59, 3);
    ev(0, 1, 0, 1);
    chk("preload.mode", int'(tc.mode), 0);
    chk_time("preload_exit", 23, 59, 0);
    ev(1, 0, 0, 59);
    chk_time("pre_roll", 23, 59, 59);
    chk("pre_roll.day_tick", int'(tc.day_tick), 0);
    ev(1, 0, 0, 1);
    chk_time("roll", 0, 0, 0);
    chk("roll.day_tick", int'(tc.day_tick), 1);
    @(negedge clk);
    chk("roll.day_tick_end", int'(tc.day_tick), 0);

    // Timeout from SET_MIN clears seconds
    ev(1, 0, 0, 37);
    ev(0, 1, 0, 2);
    chk("to_min.mode", int'(tc.mode), 2);
    ev(1, 0, 0, 9);
    chk("to_min9.mode", int'(tc.mode), 2);
    chk("to_min9.seconds", int'(tc.seconds), 37);
    chk("to_min9.blink", int'(tc.blink), 1);
    ev(1, 0, 0, 1);
    chk("to_min10.mode", int'(tc.mode), 0);
    chk("to_min10.blink", int'(tc.blink), 0);
    chk_time("to_min10", 0, 0, 0);

    // Timeout restart by inc_btn in SET_HR; seconds untouched on expiry
    ev(1, 0, 0, 5);
    ev(0, 1, 0, 1);
    ev(1, 0, 0, 9);
    ev(0, 0, 1, 1);
    chk("restart.hours", int'(tc.hours), 1);
    chk("restart.blink", int'(tc.blink), 0);
    ev(1, 0, 0, 9);
    chk("restart9.mode", int'(tc.mode), 1);
    ev(1, 0, 0, 1);
    chk("restart10.mode", int'(tc.mode), 0);
    chk_time("restart10", 1, 0, 5);

    // Simultaneous mode+inc: mode wins; tick+inc: blink and counter cleared
    ev(0, 1, 0, 1);
    ev(0, 1, 1, 1);
    chk("simul.mode", int'(tc.mode), 2);
    chk("simul.hours", int'(tc.hours), 1);
    chk("simul.minutes", int'(tc.minutes), 0);
    ev(1, 0, 0, 3);
    chk("simul3.blink", int'(tc.blink), 1);
    ev(1, 0, 1, 1);
    chk("tick_inc.blink", int'(tc.blink), 0);
    chk("tick_inc.minutes", int'(tc.minutes), 1);
    ev(1, 0, 0, 9);
    chk("tick_inc9.mode", int'(tc.mode), 2);
    chk("tick_inc9.seconds", int'(tc.seconds), 5);
    ev(1, 0, 0, 1);
    chk("tick_inc10.mode", int'(tc.mode), 0);
    chk_time("tick_inc10", 1, 1, 0);

    // Reach 14:22:05 in SET_MIN, then reset asynchronously
    ev(1, 0, 0, 5);
    ev(0, 1, 0, 1);
    ev(0, 0, 1, 13);
    ev(0, 1, 0, 1);
    ev(0, 0, 1, 21);
    chk("pre_rst.mode", int'(tc.mode), 2);
    chk_time("pre_rst", 14, 22, 5);
    #2;
    rst_n = 1'b0;
    tc.mode_btn = 1'b1;
    #1;
    chk_time("async_rst", 0, 0, 0);
    chk("async_rst.mode", int'(tc.mode), 0);
    chk("async_rst.blink", int'(tc.blink), 0);
    chk("async_rst.day_tick", int'(tc.day_tick), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("held_btn.mode", int'(tc.mode), 0);
    tc.mode_btn = 1'b0;
    @(negedge clk);
    ev(0, 1, 0, 1);
    chk("repress.mode", int'(tc.mode), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
